// File: rtl/stft_frame_scheduler_if.sv
// FFT-side stream between the frame scheduler (master) and the FFT core (slave).
// One frame is a start pulse followed by FFT_SIZE valid/ready words, then a done pulse back.
interface stft_frame_scheduler_if #(
    parameter int WORD_WIDTH = 16,
    parameter int FFT_SIZE   = 256
);
    localparam int IW = $clog2(FFT_SIZE);

    logic                  fft_start;
    logic                  fft_valid;
    logic                  fft_ready;
    logic [WORD_WIDTH-1:0] fft_data;
    logic [IW-1:0]         fft_idx;
    logic                  fft_last;
    logic                  fft_done;

    modport master (
        output fft_start, fft_valid, fft_data, fft_idx, fft_last,
        input  fft_ready, fft_done
    );

    modport slave (
        input  fft_start, fft_valid, fft_data, fft_idx, fft_last,
        output fft_ready, fft_done
    );
endinterface

// File: rtl/stft_frame_scheduler.sv
// Buffers I2S samples in a 2*FFT_SIZE ring and issues one overlapped frame every HOP samples,
// streaming it oldest-first to the FFT core and counting completed and dropped frames.
module stft_frame_scheduler #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int WORD_WIDTH   = 16,
    parameter int FFT_SIZE     = 256,
    parameter int HOP          = 128
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sample_valid,
    input  logic signed [SAMPLE_WIDTH-1:0] sample,
    input  logic                           enable,
    stft_frame_scheduler_if.master         fft,
    output logic                           busy,
    output logic [15:0]                    frame_count,
    output logic [7:0]                     overrun_count
);
    localparam int IW = $clog2(FFT_SIZE);
    localparam int PW = IW + 1;

    typedef enum logic [2:0] {S_FILL, S_IDLE, S_START, S_STREAM, S_WAIT} state_t;

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] ring_q [2*FFT_SIZE];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_base_q, rd_base_d;
    logic [IW-1:0]         cnt_q, cnt_d;
    logic                  filled_q, filled_d;
    logic                  hop_q, hop_d;
    logic                  valid_q, valid_d;
    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  last_q, last_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic [7:0]            ovr_cnt_q, ovr_cnt_d;

    logic                  launch, xfer;
    logic [IW-1:0]         idx_nxt;
    logic [PW-1:0]         rd_addr;

    generate
        if (SAMPLE_WIDTH > WORD_WIDTH) begin : g_trunc
            logic unused_lsb;
            assign unused_lsb = ^sample[SAMPLE_WIDTH-WORD_WIDTH-1:0];
        end
    endgenerate

    // Write side: one counter serves first the initial fill, then the hop spacing.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        filled_d = filled_q;
        hop_d    = 1'b0;
        if (sample_valid) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (!filled_q) begin
                if (cnt_q == IW'(FFT_SIZE - 1)) begin
                    filled_d = 1'b1;
                    hop_d    = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + IW'(1);
                end
            end else if (cnt_q == IW'(HOP - 1)) begin
                hop_d = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sample_valid) ring_q[wr_ptr_q] <= sample[SAMPLE_WIDTH-1 -: WORD_WIDTH];
    end

    assign launch  = (state_q == S_FILL || state_q == S_IDLE) && hop_q && enable;
    assign xfer    = valid_q && fft.fft_ready;
    assign idx_nxt = (state_q == S_START) ? '0 : idx_q + IW'(1);
    assign rd_addr = rd_base_q + PW'(idx_nxt);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL, S_IDLE: if (hop_q) state_d = enable ? S_START : S_IDLE;
            S_START:        state_d = S_STREAM;
            S_STREAM:       if (xfer && last_q) state_d = S_WAIT;
            S_WAIT:         if (fft.fft_done) state_d = S_IDLE;
            default:        state_d = S_FILL;
        endcase
    end

    // Output register is refilled on START and on every non-final transfer, so stalls hold it.
    always_comb begin
        rd_base_d   = rd_base_q;
        valid_d     = valid_q;
        data_d      = data_q;
        idx_d       = idx_q;
        last_d      = last_q;
        frame_cnt_d = frame_cnt_q;
        ovr_cnt_d   = ovr_cnt_q;
        if (launch) rd_base_d = wr_ptr_q - PW'(FFT_SIZE);
        if (state_q == S_START || (state_q == S_STREAM && xfer && !last_q)) begin
            valid_d = 1'b1;
            data_d  = ring_q[rd_addr];
            idx_d   = idx_nxt;
            last_d  = (idx_nxt == IW'(FFT_SIZE - 1));
        end else if (state_q == S_STREAM && xfer) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
        if (state_q == S_WAIT && fft.fft_done) frame_cnt_d = frame_cnt_q + 16'd1;
        if (hop_q && busy && ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 8'd1;
    end

    always_comb begin
        fft.fft_start = (state_q == S_START);
        busy          = (state_q == S_START) || (state_q == S_STREAM) || (state_q == S_WAIT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FILL;
            wr_ptr_q    <= '0;
            rd_base_q   <= '0;
            cnt_q       <= '0;
            filled_q    <= 1'b0;
            hop_q       <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            idx_q       <= '0;
            last_q      <= 1'b0;
            frame_cnt_q <= '0;
            ovr_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_base_q   <= rd_base_d;
            cnt_q       <= cnt_d;
            filled_q    <= filled_d;
            hop_q       <= hop_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            frame_cnt_q <= frame_cnt_d;
            ovr_cnt_q   <= ovr_cnt_d;
        end
    end

    assign fft.fft_valid  = valid_q;
    assign fft.fft_data   = data_q;
    assign fft.fft_idx    = idx_q;
    assign fft.fft_last   = last_q;
    assign frame_count    = frame_cnt_q;
    assign overrun_count  = ovr_cnt_q;
endmodule

// File: tb/tb_stft_frame_scheduler.sv
// Bench for stft_frame_scheduler: FFT_SIZE=16, HOP=8, checked against a transaction-level
// model that tracks sample history, hop points, in-flight frame and the two counters.
module tb_stft_frame_scheduler;
    localparam int N   = 16;
    localparam int HOP = 8;

    typedef struct packed {
        logic        last;
        logic [3:0]  idx;
        logic [15:0] data;
    } word_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sample_valid = 1'b0;
    logic [23:0] sample = '0;
    logic        enable = 1'b1;
    logic        busy;
    logic [15:0] frame_count;
    logic [7:0]  overrun_count;

    stft_frame_scheduler_if #(.WORD_WIDTH(16), .FFT_SIZE(N)) fif ();

    stft_frame_scheduler #(
        .SAMPLE_WIDTH(24), .WORD_WIDTH(16), .FFT_SIZE(N), .HOP(HOP)
    ) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
        .enable(enable), .fft(fif), .busy(busy), .frame_count(frame_count),
        .overrun_count(overrun_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // reference model state
    logic [15:0] hist[$];
    logic [15:0] exp_words[$];
    int          nwr = 0;
    bit          m_busy = 0;
    int          exp_frames = 0;
    int          exp_ovr = 0;
    int          exp_starts = 0;

    // monitor state
    word_t mon_words[$];
    word_t cur;
    word_t stall_w;
    bit    stall_p = 0;
    int    mon_starts = 0;
    int    stall_viol = 0;

    assign cur = {fif.fft_last, fif.fft_idx, fif.fft_data};

    always @(negedge clk) begin
        if (fif.fft_start) mon_starts <= mon_starts + 1;
        if (stall_p && (!fif.fft_valid || cur != stall_w)) stall_viol <= stall_viol + 1;
        stall_p <= fif.fft_valid && !fif.fft_ready;
        stall_w <= cur;
        if (fif.fft_valid && fif.fft_ready) mon_words.push_back(cur);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_hop();
        if (m_busy) begin
            if (exp_ovr < 255) exp_ovr++;
        end else if (enable) begin
            for (int i = 0; i < N; i++) exp_words.push_back(hist[nwr - N + i]);
            m_busy = 1;
            exp_starts++;
        end
    endtask

    task automatic send(input logic [23:0] s);
        sample = s;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        hist.push_back(s[23:8]);
        nwr++;
        if (nwr == N || (nwr > N && (nwr - N) % HOP == 0)) model_hop();
    endtask

    task automatic send_gap(input logic [23:0] s);
        send(s);
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic give_done();
        fif.fft_done = 1'b1;
        tick();
        fif.fft_done = 1'b0;
        if (m_busy) begin
            m_busy = 0;
            exp_frames++;
        end
    endtask

    task automatic wait_words(input int n, input bit rnd_ready, output bit ok);
        int cyc = 0;
        while (mon_words.size() < n && cyc < 400) begin
            if (rnd_ready) fif.fft_ready = ($urandom_range(0, 3) != 0);
            tick();
            cyc++;
        end
        fif.fft_ready = 1'b1;
        ok = (mon_words.size() >= n);
    endtask

    // Pops one frame from both queues; returns the number of words whose data, idx or last differ.
    function automatic int frame_mismatch();
        int    e = 0;
        word_t w;
        logic [15:0] x;
        for (int i = 0; i < N; i++) begin
            x = 'x;
            if (exp_words.size() != 0) x = exp_words.pop_front();
            if (mon_words.size() == 0) begin
                e++;
            end else begin
                w = mon_words.pop_front();
                if (w.data !== x || w.idx !== 4'(i) || w.last !== (i == N - 1)) e++;
            end
        end
        return e;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        total++;
        if ({fif.fft_start, fif.fft_valid, fif.fft_last, busy} !== 4'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 0000", {fif.fft_start, fif.fft_valid, fif.fft_last, busy});
        end
        total++;
        if (fif.fft_data !== 16'd0 || fif.fft_idx !== 4'd0) begin
            bad++; $display("FAIL reset_data: got data=%0h idx=%0d want 0/0", fif.fft_data, fif.fft_idx);
        end
        total++;
        if (frame_count !== 16'd0 || overrun_count !== 8'd0) begin
            bad++; $display("FAIL reset_counts: got %0d/%0d want 0/0", frame_count, overrun_count);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        bit ok;
        for (int k = 0; k < N - 1; k++) send_gap(24'(k << 8));
        repeat (3) tick();
        total++;
        if (mon_starts !== 0) begin
            bad++; $display("FAIL fill_no_start: got %0d starts want 0", mon_starts);
        end
        send(24'((N - 1) << 8));
        wait_words(N, 0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL fill_timeout: got %0d words want %0d", mon_words.size(), N); end
        total++;
        if (mon_starts !== exp_starts) begin
            bad++; $display("FAIL fill_start: got %0d starts want %0d", mon_starts, exp_starts);
        end
        total++;
        if (frame_mismatch() !== 0) begin bad++; $display("FAIL fill_frame: words differ from 0..15, want none"); end
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL fill_busy: got %b want 1", busy); end
        give_done();
        total++;
        if (frame_count !== 16'(exp_frames) || busy !== 1'b0) begin
            bad++; $display("FAIL fill_done: got count=%0d busy=%b want %0d/0", frame_count, busy, exp_frames);
        end
    endtask

    task automatic test_hop();
        bit ok;
        for (int k = 16; k < 24; k++) send_gap(24'(k << 8));
        wait_words(N, 0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL hop_timeout: got %0d words want %0d", mon_words.size(), N); end
        total++;
        if (frame_mismatch() !== 0) begin bad++; $display("FAIL hop_frame: words differ from 8..23, want none"); end
        give_done();
        total++;
        if (frame_count !== 16'(exp_frames) || overrun_count !== 8'(exp_ovr)) begin
            bad++; $display("FAIL hop_counts: got %0d/%0d want %0d/%0d", frame_count, overrun_count, exp_frames, exp_ovr);
        end
    endtask

    task automatic test_backpressure();
        int cyc = 0;
        for (int k = 24; k < 32; k++) send(24'(k << 8));
        while (mon_words.size() < N && cyc < 200) begin
            fif.fft_ready = (cyc % 2 == 0);
            tick();
            cyc++;
        end
        fif.fft_ready = 1'b1;
        repeat (4) tick();
        total++;
        if (mon_words.size() !== N) begin
            bad++; $display("FAIL bp_transfers: got %0d want %0d", mon_words.size(), N);
        end
        total++;
        if (stall_viol !== 0) begin bad++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_viol); end
        total++;
        if (frame_mismatch() !== 0) begin bad++; $display("FAIL bp_frame: words differ from 16..31, want none"); end
        give_done();
        total++;
        if (frame_count !== 16'(exp_frames)) begin
            bad++; $display("FAIL bp_count: got %0d want %0d", frame_count, exp_frames);
        end
    endtask

    task automatic test_overrun();
        bit ok;
        for (int k = 32; k < 40; k++) send(24'(k << 8));
        wait_words(N, 0, ok);
        total++;
        if (frame_mismatch() !== 0 || !ok) begin bad++; $display("FAIL ovr_frame1: words differ from 24..39, want none"); end
        for (int k = 40; k < 48; k++) send_gap(24'(k << 8));
        repeat (2) tick();
        total++;
        if (overrun_count !== 8'(exp_ovr) || mon_starts !== exp_starts) begin
            bad++; $display("FAIL ovr_drop: got ovr=%0d starts=%0d want %0d/%0d", overrun_count, mon_starts, exp_ovr, exp_starts);
        end
        give_done();
        for (int k = 48; k < 56; k++) send_gap(24'(k << 8));
        wait_words(N, 0, ok);
        total++;
        if (frame_mismatch() !== 0 || !ok) begin bad++; $display("FAIL ovr_latest: words differ from 40..55, want none"); end
        // hop pulse lands in the same cycle as fft_done
        for (int k = 56; k < 63; k++) send(24'(k << 8));
        send(24'(63 << 8));
        give_done();
        repeat (3) tick();
        total++;
        if (overrun_count !== 8'(exp_ovr) || frame_count !== 16'(exp_frames)) begin
            bad++; $display("FAIL ovr_same_cycle: got ovr=%0d frames=%0d want %0d/%0d", overrun_count, frame_count, exp_ovr, exp_frames);
        end
        total++;
        if (mon_starts !== exp_starts || busy !== 1'b0) begin
            bad++; $display("FAIL ovr_no_start: got starts=%0d busy=%b want %0d/0", mon_starts, busy, exp_starts);
        end
    endtask

    task automatic test_enable();
        bit ok;
        int cyc = 0;
        enable = 1'b0;
        for (int k = 64; k < 72; k++) send_gap(24'(k << 8));
        repeat (3) tick();
        total++;
        if (mon_starts !== exp_starts || frame_count !== 16'(exp_frames) || overrun_count !== 8'(exp_ovr) || busy !== 1'b0) begin
            bad++; $display("FAIL en_ignored: got starts=%0d frames=%0d ovr=%0d busy=%b want %0d/%0d/%0d/0",
                            mon_starts, frame_count, overrun_count, busy, exp_starts, exp_frames, exp_ovr);
        end
        enable = 1'b1;
        for (int k = 72; k < 80; k++) send(24'(k << 8));
        while (mon_starts < exp_starts && cyc < 20) begin tick(); cyc++; end
        enable = 1'b0;
        wait_words(N, 0, ok);
        total++;
        if (frame_mismatch() !== 0 || !ok) begin bad++; $display("FAIL en_frame: words differ from 64..79, want none"); end
        give_done();
        total++;
        if (frame_count !== 16'(exp_frames) || mon_starts !== exp_starts) begin
            bad++; $display("FAIL en_complete: got frames=%0d starts=%0d want %0d/%0d", frame_count, mon_starts, exp_frames, exp_starts);
        end
        enable = 1'b1;
    endtask

    task automatic test_random();
        bit ok;
        int errs = 0;
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < HOP; k++) send_gap(24'($urandom));
            wait_words(N, 1, ok);
            if (!ok) errs++;
            errs += frame_mismatch();
            give_done();
        end
        total++;
        if (errs !== 0) begin bad++; $display("FAIL rnd_frames: got %0d bad words want 0", errs); end
        total++;
        if (frame_count !== 16'(exp_frames) || overrun_count !== 8'(exp_ovr) || stall_viol !== 0) begin
            bad++; $display("FAIL rnd_counts: got %0d/%0d stalls=%0d want %0d/%0d/0",
                            frame_count, overrun_count, stall_viol, exp_frames, exp_ovr);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int cyc = 0;
        for (int k = 0; k < HOP; k++) send(24'($urandom));
        while (mon_words.size() < 5 && cyc < 100) begin tick(); cyc++; end
        total++;
        if (fif.fft_idx !== 4'd5 || fif.fft_valid !== 1'b1) begin
            bad++; $display("FAIL rst_pre: got idx=%0d valid=%b want 5/1", fif.fft_idx, fif.fft_valid);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({fif.fft_start, fif.fft_valid, fif.fft_last, busy} !== 4'b0 || fif.fft_data !== 16'd0 ||
            fif.fft_idx !== 4'd0 || frame_count !== 16'd0 || overrun_count !== 8'd0) begin
            bad++; $display("FAIL rst_async: got flags=%b data=%0h idx=%0d counts=%0d/%0d want all 0",
                            {fif.fft_start, fif.fft_valid, fif.fft_last, busy}, fif.fft_data, fif.fft_idx,
                            frame_count, overrun_count);
        end
        hist.delete(); exp_words.delete(); mon_words.delete();
        nwr = 0; m_busy = 0; exp_frames = 0; exp_ovr = 0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        for (int k = 0; k < N - 1; k++) send_gap(24'((k + 100) << 8));
        repeat (3) tick();
        total++;
        if (mon_starts !== exp_starts) begin
            bad++; $display("FAIL rst_refill: got %0d starts want %0d", mon_starts, exp_starts);
        end
        send(24'((N - 1 + 100) << 8));
        wait_words(N, 0, ok);
        total++;
        if (frame_mismatch() !== 0 || !ok) begin bad++; $display("FAIL rst_frame: words differ from 100..115, want none"); end
        give_done();
        total++;
        if (frame_count !== 16'(exp_frames) || mon_starts !== exp_starts) begin
            bad++; $display("FAIL rst_count: got frames=%0d starts=%0d want %0d/%0d", frame_count, mon_starts, exp_frames, exp_starts);
        end
    endtask

    initial begin
        fif.fft_ready = 1'b1;
        fif.fft_done  = 1'b0;
        test_reset();
        test_fill();
        test_hop();
        test_backpressure();
        test_overrun();
        test_enable();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
